line_buf_arbiter: RTL

Ping-pong manager for the two input linebuffer banks. It sits between the input buffer controller, which writes one video line per bank, and the downstream line reader. It steers writer traffic into whichever bank is filling and grants completed lines to the reader in arrival order. When no free bank exists it detects the overflow and drops the line.

---
 rtl/line_buf_arbiter_if.sv | 45 ++++
 rtl/line_buf_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/line_buf_arbiter_if.sv
// Writer, reader and bank-port signals of the linebuffer ping-pong arbiter.
// Latency: n/a (signal bundle only).
// Backpressure: none; the reader holds rd_req until granted.
interface line_buf_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  // writer side
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  line_valid;
  logic                  frame_valid;
  // bank write port
  logic                  buf_wr_en;
  logic [ADDR_WIDTH:0]   buf_wr_addr;
  logic [DATA_WIDTH-1:0] buf_wr_data;
  // reader side
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_done;
  logic                  rd_grant;
  logic                  rd_bank;
  logic                  rd_last;
  logic [ADDR_WIDTH:0]   buf_rd_addr;
  // overflow reporting
  logic                  drop;
  logic [7:0]            drop_count;

  modport slave (
    input  wr_en, wr_addr, wr_data, line_valid, frame_valid,
    input  rd_req, rd_addr, rd_done,
    output buf_wr_en, buf_wr_addr, buf_wr_data,
    output rd_grant, rd_bank, rd_last, buf_rd_addr,
    output drop, drop_count
  );

  modport master (
    output wr_en, wr_addr, wr_data, line_valid, frame_valid,
    output rd_req, rd_addr, rd_done,
    input  buf_wr_en, buf_wr_addr, buf_wr_data,
    input  rd_grant, rd_bank, rd_last, buf_rd_addr,
    input  drop, drop_count
  );
endinterface

// File: rtl/line_buf_arbiter.sv
// Ping-pong manager for two linebuffer banks: steers writes, grants full lines in order.
// Latency: write path 1 cycle; grant 1 cycle after rd_req with a FULL bank.
// Backpressure: none to writer; a line completing with no free bank is dropped.
module line_buf_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic               pclk,
  input  logic               reset,
  line_buf_arbiter_if.slave  bus
);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_FILLING = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;
  localparam logic [1:0] S_READING = 2'd3;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_GRANT = 1'b1;

  logic [1:0][1:0]       bank_state_q, bank_state_d;
  logic [1:0]            last_q, last_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [0:0]            rd_state_q, rd_state_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  drop_q, drop_d;
  logic [7:0]            drop_count_q, drop_count_d;
  logic                  buf_wr_en_q, buf_wr_en_d;
  logic [ADDR_WIDTH:0]   buf_wr_addr_q, buf_wr_addr_d;
  logic [DATA_WIDTH-1:0] buf_wr_data_q, buf_wr_data_d;

  logic other_bank;
  logic rd_release;
  logic other_free;

  // A bank being released this cycle already counts as EMPTY for a completing line.
  assign other_bank = ~wr_bank_q;
  assign rd_release = (rd_state_q == R_GRANT) && bus.rd_done;
  assign other_free = (bank_state_q[other_bank] == S_EMPTY) ||
                      (rd_release && (rd_bank_q == other_bank));

  // Next-state for bank ownership, reader FSM, overflow and the registered write port.
  always_comb begin
    bank_state_d  = bank_state_q;
    last_d        = last_q;
    wr_bank_d     = wr_bank_q;
    rd_state_d    = rd_state_q;
    rd_bank_d     = rd_bank_q;
    drop_d        = 1'b0;
    drop_count_d  = drop_count_q;
    buf_wr_en_d   = bus.wr_en;
    buf_wr_addr_d = {wr_bank_q, bus.wr_addr};
    buf_wr_data_d = bus.wr_data;

    // Reader: grants only sample registered FULL, so a line completing now waits a cycle.
    if (rd_state_q == R_IDLE) begin
      if (bus.rd_req && (bank_state_q[rd_bank_q] == S_FULL)) begin
        bank_state_d[rd_bank_q] = S_READING;
        rd_state_d              = R_GRANT;
      end
    end else if (bus.rd_done) begin
      bank_state_d[rd_bank_q] = S_EMPTY;
      last_d[rd_bank_q]       = 1'b0;
      rd_state_d              = R_IDLE;
      rd_bank_d               = ~rd_bank_q;
    end

    // Writer: hand the finished bank over, or overwrite it in place when nothing is free.
    if (bus.line_valid) begin
      if (other_free) begin
        bank_state_d[wr_bank_q]  = S_FULL;
        last_d[wr_bank_q]        = bus.frame_valid;
        bank_state_d[other_bank] = S_FILLING;
        wr_bank_d                = other_bank;
      end else begin
        drop_d = 1'b1;
        if (drop_count_q != 8'hFF) begin
          drop_count_d = drop_count_q + 8'd1;
        end
      end
    end
  end

  // State registers; reset abandons any partial line or active grant immediately.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      bank_state_q  <= {S_EMPTY, S_FILLING};
      last_q        <= 2'b00;
      wr_bank_q     <= 1'b0;
      rd_state_q    <= R_IDLE;
      rd_bank_q     <= 1'b0;
      drop_q        <= 1'b0;
      drop_count_q  <= 8'd0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
      buf_wr_data_q <= '0;
    end else begin
      bank_state_q  <= bank_state_d;
      last_q        <= last_d;
      wr_bank_q     <= wr_bank_d;
      rd_state_q    <= rd_state_d;
      rd_bank_q     <= rd_bank_d;
      drop_q        <= drop_d;
      drop_count_q  <= drop_count_d;
      buf_wr_en_q   <= buf_wr_en_d;
      buf_wr_addr_q <= buf_wr_addr_d;
      buf_wr_data_q <= buf_wr_data_d;
    end
  end

  assign bus.buf_wr_en   = buf_wr_en_q;
  assign bus.buf_wr_addr = buf_wr_addr_q;
  assign bus.buf_wr_data = buf_wr_data_q;
  assign bus.rd_grant    = (rd_state_q == R_GRANT);
  assign bus.rd_bank     = rd_bank_q;
  assign bus.rd_last     = (rd_state_q == R_GRANT) && last_q[rd_bank_q];
  assign bus.buf_rd_addr = {rd_bank_q, bus.rd_addr};
  assign bus.drop        = drop_q;
  assign bus.drop_count  = drop_count_q;

endmodule
